// File: rtl/quant_div_pipe.sv
// quant_div_pipe: pipelined restoring divider, q = floor(act/unit) saturated
// to Q_W bits plus remainder, one result per cycle with valid/ready on both
// sides and a tag carried alongside each operand pair.
// Ports: clk, rst (async, active-high); i_valid/i_ready/i_act/i_unit/i_tag in;
//        o_valid/o_ready/o_q/o_rem/o_sat/o_dz/o_tag out.
// Optional: define QUANT_DIV_ROUND_EN for a round-half-up stage (+1 latency).
module quant_div_pipe #(
    parameter int DATA_W = 32,
    parameter int Q_W    = 8,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [DATA_W-1:0] i_act,
    input  logic [DATA_W-1:0] i_unit,
    input  logic [TAG_W-1:0]  i_tag,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [Q_W-1:0]    o_q,
    output logic [DATA_W-1:0] o_rem,
    output logic              o_sat,
    output logic              o_dz,
    output logic [TAG_W-1:0]  o_tag
);

    localparam int RW = DATA_W + Q_W - 1;
    localparam int NS = Q_W + 1;
    localparam logic [Q_W-1:0] Q_MAX = '1;

    logic              v_q    [0:NS-1];
    logic              v_d    [0:NS-1];
    logic [RW-1:0]     rem_q  [0:NS-1];
    logic [RW-1:0]     rem_d  [0:NS-1];
    logic [RW-1:0]     div_q  [0:NS-1];
    logic [RW-1:0]     div_d  [0:NS-1];
    logic [Q_W-1:0]    quo_q  [0:NS-1];
    logic [Q_W-1:0]    quo_d  [0:NS-1];
    logic [DATA_W-1:0] unit_q [0:NS-1];
    logic [DATA_W-1:0] unit_d [0:NS-1];
    logic [TAG_W-1:0]  tag_q  [0:NS-1];
    logic [TAG_W-1:0]  tag_d  [0:NS-1];
    logic              sat_q  [0:NS-1];
    logic              sat_d  [0:NS-1];
    logic              dz_q   [0:NS-1];
    logic              dz_d   [0:NS-1];

    logic                  adv;
    logic                  s0_dz;
    logic                  s0_sat;
    logic [DATA_W+Q_W-1:0] act_w;
    logic [DATA_W+Q_W-1:0] lim_w;
    logic [Q_W-1:0]        ge;

    assign adv     = !o_valid || o_ready;
    assign i_ready = adv;

    // Saturation test is done one bit wider than the internal datapath so
    // unit << Q_W never overflows.
    assign act_w  = (DATA_W+Q_W)'(i_act);
    assign lim_w  = {i_unit, Q_W'(0)};
    assign s0_dz  = (i_unit == '0);
    assign s0_sat = !s0_dz && (act_w >= lim_w);

    // ge[k] is the quotient bit produced when stage k feeds stage k+1.
    always_comb begin
        ge = '0;
        for (int k = 0; k < Q_W; k++) begin
            ge[k] = (rem_q[k] >= div_q[k]);
        end
    end

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            v_d[k]    = v_q[k];
            rem_d[k]  = rem_q[k];
            div_d[k]  = div_q[k];
            quo_d[k]  = quo_q[k];
            unit_d[k] = unit_q[k];
            tag_d[k]  = tag_q[k];
            sat_d[k]  = sat_q[k];
            dz_d[k]   = dz_q[k];
        end
        if (adv) begin
            v_d[0]    = i_valid;
            rem_d[0]  = RW'(i_act);
            div_d[0]  = RW'(i_unit) << (Q_W - 1);
            quo_d[0]  = '0;
            unit_d[0] = i_unit;
            tag_d[0]  = i_tag;
            sat_d[0]  = s0_sat;
            dz_d[0]   = s0_dz;
            // A zero divisor subtracts nothing each stage, which yields
            // q = all-ones and rem = act without special handling.
            for (int k = 1; k < NS; k++) begin
                v_d[k]    = v_q[k-1];
                rem_d[k]  = ge[k-1] ? rem_q[k-1] - div_q[k-1] : rem_q[k-1];
                div_d[k]  = div_q[k-1] >> 1;
                quo_d[k]  = Q_W'({quo_q[k-1], ge[k-1]});
                unit_d[k] = unit_q[k-1];
                tag_d[k]  = tag_q[k-1];
                sat_d[k]  = sat_q[k-1];
                dz_d[k]   = dz_q[k-1];
            end
            if (sat_q[NS-2]) begin
                quo_d[NS-1] = Q_MAX;
                rem_d[NS-1] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NS; k++) begin
                v_q[k]    <= 1'b0;
                rem_q[k]  <= '0;
                div_q[k]  <= '0;
                quo_q[k]  <= '0;
                unit_q[k] <= '0;
                tag_q[k]  <= '0;
                sat_q[k]  <= 1'b0;
                dz_q[k]   <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NS; k++) begin
                v_q[k]    <= v_d[k];
                rem_q[k]  <= rem_d[k];
                div_q[k]  <= div_d[k];
                quo_q[k]  <= quo_d[k];
                unit_q[k] <= unit_d[k];
                tag_q[k]  <= tag_d[k];
                sat_q[k]  <= sat_d[k];
                dz_q[k]   <= dz_d[k];
            end
        end
    end

`ifdef QUANT_DIV_ROUND_EN
    logic              r_v_q,   r_v_d;
    logic [Q_W-1:0]    r_q_q,   r_q_d;
    logic [DATA_W-1:0] r_rem_q, r_rem_d;
    logic              r_sat_q, r_sat_d;
    logic              r_dz_q,  r_dz_d;
    logic [TAG_W-1:0]  r_tag_q, r_tag_d;

    logic [DATA_W-1:0] rem_lo;
    logic              rnd;
    logic              q_full;

    // rem < unit here, so the low DATA_W bits hold the whole remainder.
    assign rem_lo = rem_q[NS-1][DATA_W-1:0];
    assign q_full = (quo_q[NS-1] == Q_MAX);
    assign rnd    = !sat_q[NS-1] && !dz_q[NS-1] &&
                    ({rem_lo, 1'b0} >= {1'b0, unit_q[NS-1]});

    always_comb begin
        r_v_d   = r_v_q;
        r_q_d   = r_q_q;
        r_rem_d = r_rem_q;
        r_sat_d = r_sat_q;
        r_dz_d  = r_dz_q;
        r_tag_d = r_tag_q;
        if (adv) begin
            r_v_d   = v_q[NS-1];
            r_q_d   = (rnd && !q_full) ? quo_q[NS-1] + 1'b1 : quo_q[NS-1];
            r_rem_d = rnd ? rem_lo - unit_q[NS-1] : rem_lo;
            r_sat_d = sat_q[NS-1] || (rnd && q_full);
            r_dz_d  = dz_q[NS-1];
            r_tag_d = tag_q[NS-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v_q   <= 1'b0;
            r_q_q   <= '0;
            r_rem_q <= '0;
            r_sat_q <= 1'b0;
            r_dz_q  <= 1'b0;
            r_tag_q <= '0;
        end else begin
            r_v_q   <= r_v_d;
            r_q_q   <= r_q_d;
            r_rem_q <= r_rem_d;
            r_sat_q <= r_sat_d;
            r_dz_q  <= r_dz_d;
            r_tag_q <= r_tag_d;
        end
    end

    assign o_valid = r_v_q;
    assign o_q     = r_q_q;
    assign o_rem   = r_rem_q;
    assign o_sat   = r_sat_q;
    assign o_dz    = r_dz_q;
    assign o_tag   = r_tag_q;
`else
    assign o_valid = v_q[NS-1];
    assign o_q     = quo_q[NS-1];
    assign o_rem   = rem_q[NS-1][DATA_W-1:0];
    assign o_sat   = sat_q[NS-1];
    assign o_dz    = dz_q[NS-1];
    assign o_tag   = tag_q[NS-1];
`endif

endmodule

// File: tb/tb_quant_div_pipe.sv
// tb_quant_div_pipe: directed bench for quant_div_pipe with a queue-based
// arithmetic reference model and hand-computed literal checks.
module tb_quant_div_pipe;

    localparam int DW = 32;
    localparam int QW = 8;
    localparam int TW = 4;
`ifdef QUANT_DIV_ROUND_EN
    localparam int LAT = QW + 2;
`else
    localparam int LAT = QW + 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_act;
    logic [DW-1:0] i_unit;
    logic [TW-1:0] i_tag;
    logic          o_valid;
    logic          o_ready;
    logic [QW-1:0] o_q;
    logic [DW-1:0] o_rem;
    logic          o_sat;
    logic          o_dz;
    logic [TW-1:0] o_tag;

    quant_div_pipe #(.DATA_W(DW), .Q_W(QW), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready),
        .i_act(i_act), .i_unit(i_unit), .i_tag(i_tag),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_q(o_q), .o_rem(o_rem), .o_sat(o_sat), .o_dz(o_dz), .o_tag(o_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [QW-1:0] q;
        logic [DW-1:0] rem;
        logic          sat;
        logic          dz;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t eq[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers = 0;
    int   run_len = 0;
    int   last_run = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Reference: plain integer division, then saturation / rounding rules.
    function automatic exp_t model(input logic [DW-1:0] a,
                                   input logic [DW-1:0] u,
                                   input logic [TW-1:0] t);
        exp_t e;
        logic [63:0] tq;
        e.tag = t;
        e.sat = 1'b0;
        e.dz  = 1'b0;
        if (u == 0) begin
            e.q   = '1;
            e.rem = a;
            e.dz  = 1'b1;
        end else begin
            tq = {32'b0, a} / {32'b0, u};
            if (tq > 64'd255) begin
                e.q   = '1;
                e.rem = '0;
                e.sat = 1'b1;
            end else begin
                e.q   = tq[QW-1:0];
                e.rem = a % u;
`ifdef QUANT_DIV_ROUND_EN
                if (({32'b0, e.rem} * 2) >= {32'b0, u}) begin
                    if (e.q == 8'hFF) e.sat = 1'b1;
                    else e.q = e.q + 8'd1;
                    e.rem = e.rem - u;
                end
`endif
            end
        end
        return e;
    endfunction

    // Compare process: every negedge, check handshake and any valid output.
    always @(negedge clk) begin
        if (rst) begin
            eq.delete();
            run_len = 0;
        end else begin
            chk("i_ready", {63'b0, i_ready}, {63'b0, (!o_valid || o_ready)});
            if (o_valid) begin
                run_len++;
                if (eq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious: got q=%0h tag=%0h expected none",
                             o_q, o_tag);
                end else begin
                    chk("m_q",   {56'b0, o_q},   {56'b0, eq[0].q});
                    chk("m_rem", {32'b0, o_rem}, {32'b0, eq[0].rem});
                    chk("m_sat", {63'b0, o_sat}, {63'b0, eq[0].sat});
                    chk("m_dz",  {63'b0, o_dz},  {63'b0, eq[0].dz});
                    chk("m_tag", {60'b0, o_tag}, {60'b0, eq[0].tag});
                    if (o_ready) begin
                        void'(eq.pop_front());
                        xfers++;
                    end
                end
            end else begin
                if (run_len > 0) last_run = run_len;
                run_len = 0;
            end
            if (i_valid && i_ready) eq.push_back(model(i_act, i_unit, i_tag));
        end
    end

    task automatic send_one(input logic [DW-1:0] a, input logic [DW-1:0] u,
                            input logic [TW-1:0] t, input logic [QW-1:0] eqv,
                            input logic [DW-1:0] erem, input logic esat,
                            input logic edz);
        int n;
        i_valid = 1'b1;
        i_act   = a;
        i_unit  = u;
        i_tag   = t;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        n = 1;
        while (!o_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 64'(n), 64'(LAT));
        chk("d_q",   {56'b0, o_q},   {56'b0, eqv});
        chk("d_rem", {32'b0, o_rem}, {32'b0, erem});
        chk("d_sat", {63'b0, o_sat}, {63'b0, esat});
        chk("d_dz",  {63'b0, o_dz},  {63'b0, edz});
        chk("d_tag", {60'b0, o_tag}, {60'b0, t});
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input bit stall);
        int  i = 0;
        int  c = 0;
        bit  acc;
        while (i < 20 && c < 200) begin
            i_valid = 1'b1;
            i_act   = DW'(i * 13);
            i_unit  = 32'd5;
            i_tag   = TW'(i % 16);
            if (stall) o_ready = !(c >= 12 && c < 15);
            @(negedge clk);
            acc = i_ready;
            if (stall && c == 13) chk("stall_iready", {63'b0, i_ready}, 64'd0);
            @(posedge clk);
            #1;
            if (acc) i++;
            c++;
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        chk("stream_sent", 64'(i), 64'd20);
    endtask

    task automatic drain();
        int n = 0;
        while (n < 100 && (eq.size() != 0 || o_valid)) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 64'(eq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int x0;
        int seen;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_act   = '0;
        i_unit  = '0;
        i_tag   = '0;
        o_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'b0, o_valid}, 64'd0);
        chk("rst_q",     {56'b0, o_q},     64'd0);
        chk("rst_rem",   {32'b0, o_rem},   64'd0);
        chk("rst_flags", {62'b0, o_sat, o_dz}, 64'd0);
        chk("rst_tag",   {60'b0, o_tag},   64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send_one(32'd100,  32'd7, 4'd3, 8'd14,  32'd2,  1'b0, 1'b0);
        send_one(32'd5000, 32'd7, 4'd1, 8'd255, 32'd0,  1'b1, 1'b0);
        send_one(32'd1785, 32'd7, 4'd2, 8'd255, 32'd0,  1'b0, 1'b0);
        send_one(32'd1792, 32'd7, 4'd4, 8'd255, 32'd0,  1'b1, 1'b0);
        send_one(32'd42,   32'd0, 4'd5, 8'd255, 32'd42, 1'b0, 1'b1);
        send_one(32'd0,    32'd9, 4'd6, 8'd0,   32'd0,  1'b0, 1'b0);
        send_one(32'd3,    32'd9, 4'd7, 8'd0,   32'd3,  1'b0, 1'b0);
`ifdef QUANT_DIV_ROUND_EN
        send_one(32'd13,   32'd4, 4'd8, 8'd3,   32'd1,  1'b0, 1'b0);
        send_one(32'd14,   32'd4, 4'd9, 8'd4,   32'hFFFFFFFE, 1'b0, 1'b0);
        send_one(32'd1790, 32'd7, 4'hA, 8'd255, 32'hFFFFFFFE, 1'b1, 1'b0);
`else
        send_one(32'd13,   32'd4, 4'd8, 8'd3,   32'd1,  1'b0, 1'b0);
        send_one(32'd14,   32'd4, 4'd9, 8'd3,   32'd2,  1'b0, 1'b0);
        send_one(32'd1790, 32'd7, 4'hA, 8'd255, 32'd5,  1'b0, 1'b0);
`endif

        x0 = xfers;
        stream(1'b0);
        drain();
        chk("run_len", 64'(last_run), 64'd20);
        chk("xfers_a", 64'(xfers - x0), 64'd20);

        x0 = xfers;
        stream(1'b1);
        drain();
        chk("xfers_b", 64'(xfers - x0), 64'd20);

        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            i_act   = DW'(100 + i);
            i_unit  = 32'd3;
            i_tag   = TW'(i);
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {63'b0, o_valid}, 64'd0);
        chk("mid_rst_out", {o_q, o_rem, o_sat, o_dz, o_tag}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (o_valid) seen++;
        end
        chk("no_stale", 64'(seen), 64'd0);
        send_one(32'd72, 32'd8, 4'd5, 8'd9, 32'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quant_div_pipe.md
Name: quant_div_pipe

Overview:
Parametrised, fully pipelined restoring divider for activation quantisation. Computes q = floor(act / unit), saturated to Q_W bits, plus the remainder, at one result per cycle. Sits between the accumulator/activation stage and the quantised-output packer, using valid/ready handshakes on both sides. A tag field travels with each operand pair so downstream logic can re-associate results.

Parameters:
DATA_W, 32, width of activation, unit and remainder (unsigned)
Q_W, 8, quotient width; also the number of divide stages (1..16)
TAG_W, 4, width of the sideband tag carried alongside the data

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
i_valid  in  1  input operand pair valid
i_ready  out  1  pipeline can accept input this cycle
i_act  in  DATA_W  activation (unsigned dividend)
i_unit  in  DATA_W  quantisation step (unsigned divisor)
i_tag  in  TAG_W  sideband tag
o_valid  out  1  result valid
o_ready  in  1  downstream accepts result
o_q  out  Q_W  quotient, saturated
o_rem  out  DATA_W  remainder
o_sat  out  1  quotient saturated (act >= unit<<Q_W)
o_dz  out  1  divide by zero (unit == 0)
o_tag  out  TAG_W  tag of this result

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All stage valid bits, o_valid, o_q, o_rem, o_sat, o_dz and o_tag reset to 0. An assertion mid-operation flushes every in-flight item; nothing is emitted afterwards for items that were in flight.
- Pipeline: one entry stage S0, then Q_W divide stages S1..S_Q_W. The last stage drives the outputs directly. Latency is Q_W+1 cycles from input acceptance to o_valid (9 at default).
- Global advance enable: adv = !o_valid | o_ready. Set i_ready = adv. An input transfers when i_valid & i_ready. When adv=0, every stage register holds, including data and valid bits. Bubbles are not collapsed.
- S0:
  - Registers act, unit, tag and valid.
  - Computes dz = (unit == 0).
  - Computes sat = !dz & (act >= unit * 2^Q_W), evaluated at width DATA_W+Q_W.
  - Loads the working divisor d = unit << (Q_W-1), width DATA_W+Q_W-1, so no bits are lost.
- Stage k (k = 1..Q_W):
  - If rem >= d: rem -= d and shift in quotient bit 1; otherwise shift in 0.
  - Then d >>= 1.
  - Quotient is built MSB first. rem = 0 and act < unit both naturally produce bit 0.
- Final results:
  - Normal: o_q = floor(act/unit), o_rem = act mod unit.
  - sat=1: o_q = 2^Q_W-1, o_rem = 0.
  - dz=1: o_q = 2^Q_W-1, o_rem = act, o_sat = 0.
  - dz and sat are never both 1.
- Widths: all arithmetic is unsigned. Internal remainder and divisor are DATA_W+Q_W-1 bits. o_rem is the low DATA_W bits, which is always exact because rem < unit.
- Ordering: results leave in acceptance order. Tags pass through unchanged.
- Output hold: while o_valid & !o_ready, all outputs are stable.
- Simultaneous events: a new input can be accepted in the same cycle an output is consumed, giving full throughput with o_ready held high.

Optional Feature:
QUANT_DIV_ROUND_EN
- Defined:
  - Adds one rounding stage after S_Q_W; latency becomes Q_W+2.
  - If !sat & !dz & (2*rem >= unit), q = q+1, saturating at 2^Q_W-1. On an increment, o_sat=1 if q was already all-ones before the increment.
  - o_rem = rem - unit when incremented, taken as the two's-complement low DATA_W bits; otherwise rem.
  - The rounding stage obeys the same adv stall.
- Undefined: truncating division only; latency Q_W+1.

Test Plan:
Defaults used throughout (DATA_W=32, Q_W=8).
- act=100, unit=7, tag=3, o_ready=1 -> 9 cycles later o_valid=1, o_q=14, o_rem=2, o_sat=0, o_dz=0, o_tag=3.
- act=5000, unit=7 -> o_q=255, o_sat=1, o_rem=0. act=1785, unit=7 (=255*7) -> o_q=255, o_sat=0, o_rem=0. act=1792 -> o_sat=1.
- unit=0, act=42 -> o_q=255, o_dz=1, o_rem=42. act=0, unit=9 -> o_q=0, o_rem=0. act=3, unit=9 -> o_q=0, o_rem=3.
- Stream 20 back-to-back pairs (act=i*13, unit=5, tag=i%16) with o_ready=1 -> 20 consecutive o_valid cycles, correct order and values. Then drop o_ready for 3 cycles mid-stream -> i_ready=0, outputs frozen, no loss or duplication after resume.
- Assert rst for 1 cycle with 5 items in flight -> o_valid=0 immediately, all outputs 0, no stale results afterwards. The first new input after reset appears after exactly 9 cycles.
- QUANT_DIV_ROUND_EN defined:
  - act=13, unit=4 -> o_q=3, o_rem=1.
  - act=14, unit=4 -> o_q=4, o_rem=0xFFFFFFFE.
  - act=1790, unit=7 -> o_q=255, o_sat=1.
  - Latency is 10 cycles.
